score_tracker_multi: RTL and testbench

//  Parametrised successor to the game's score tracker. Keeps a personal-best table for NUM_PLAYERS players
//  and the global best with its owner. Processes one request at a time (SUBMIT / QUERY / CLEAR) over a

---
 rtl/score_tracker_multi.sv | 158 +++++++++++++++
 tb/tb_score_tracker_multi.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/score_tracker_multi.sv
// Personal-best table for NUM_PLAYERS players plus the global best and its owner.
// One SUBMIT/QUERY/CLEAR request at a time over valid/ready, with a one-cycle response strobe.
module score_tracker_multi #(
    parameter int NUM_PLAYERS = 4,
    parameter int ID_W        = 2,
    parameter int SCORE_W     = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [ID_W-1:0]    req_id,
    input  logic [SCORE_W-1:0] req_score,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic               personal_winner,
    output logic               global_winner,
    output logic [SCORE_W-1:0] rsp_score,
    output logic [SCORE_W-1:0] global_best,
    output logic [ID_W-1:0]    global_owner
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, SCAN, RESP} state_t;

    localparam logic [1:0] OP_SUBMIT = 2'd0;
    localparam logic [1:0] OP_QUERY  = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;
    localparam int         CNT_W     = $clog2(NUM_PLAYERS + 1);
    localparam logic [ID_W:0]  NP_ID  = (ID_W + 1)'(NUM_PLAYERS);
    localparam logic [CNT_W-1:0] NP_CNT = CNT_W'(NUM_PLAYERS);

    state_t             state, state_next;
    logic [SCORE_W-1:0] best_tab [NUM_PLAYERS];
    logic [1:0]         op_q;
    logic [ID_W-1:0]    id_q;
    logic [SCORE_W-1:0] score_q;
    logic               bad_q;
    logic [SCORE_W-1:0] cur;
    logic [CNT_W-1:0]   scan_idx;
    logic [SCORE_W-1:0] scan_best;
    logic [ID_W-1:0]    scan_owner;

    logic [SCORE_W-1:0] rd_cur;
    logic [SCORE_W-1:0] scan_val;
    logic               pw;
    logic               gw;
    logic               owner_hit;

    assign req_ready = (state == IDLE);
    assign pw        = score_q > cur;
    assign gw        = score_q > global_best;
    assign owner_hit = !bad_q && (op_q == OP_CLEAR) && (id_q == global_owner)
                       && (global_best != '0);

    always_comb begin
        rd_cur   = '0;
        scan_val = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (id_q == ID_W'(i))
                rd_cur = best_tab[i];
            if (scan_idx == CNT_W'(i))
                scan_val = best_tab[i];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) state_next = READ;
            READ: state_next = EXEC;
            EXEC: state_next = owner_hit ? SCAN : RESP;
            // NUM_PLAYERS read cycles plus one commit cycle at scan_idx == NUM_PLAYERS
            SCAN: if (scan_idx == NP_CNT) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            op_q            <= '0;
            id_q            <= '0;
            score_q         <= '0;
            bad_q           <= 1'b0;
            cur             <= '0;
            scan_idx        <= '0;
            scan_best       <= '0;
            scan_owner      <= '0;
            rsp_valid       <= 1'b0;
            rsp_err         <= 1'b0;
            personal_winner <= 1'b0;
            global_winner   <= 1'b0;
            rsp_score       <= '0;
            global_best     <= '0;
            global_owner    <= '0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++)
                best_tab[i] <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= (state_next == RESP);
            case (state)
                IDLE: if (req_valid) begin
                    op_q    <= req_op;
                    id_q    <= req_id;
                    score_q <= req_score;
                    bad_q   <= ({1'b0, req_id} >= NP_ID) || (req_op == OP_RSVD);
                end
                READ: cur <= rd_cur;
                EXEC: begin
                    rsp_err         <= bad_q;
                    personal_winner <= 1'b0;
                    global_winner   <= 1'b0;
                    rsp_score       <= '0;
                    scan_idx        <= '0;
                    scan_best       <= '0;
                    scan_owner      <= '0;
                    if (!bad_q) begin
                        case (op_q)
                            OP_SUBMIT: begin
                                personal_winner <= pw;
                                global_winner   <= gw;
                                rsp_score       <= pw ? score_q : cur;
                                if (gw) begin
                                    global_best  <= score_q;
                                    global_owner <= id_q;
                                end
                            end
                            OP_QUERY: rsp_score <= cur;
                            default: ;
                        endcase
                        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                            if (id_q == ID_W'(i)) begin
                                if (op_q == OP_SUBMIT && pw)
                                    best_tab[i] <= score_q;
                                else if (op_q == OP_CLEAR)
                                    best_tab[i] <= '0;
                            end
                        end
                    end
                end
                SCAN: begin
                    if (scan_idx == NP_CNT) begin
                        global_best  <= scan_best;
                        global_owner <= scan_owner;
                    end else if (scan_val > scan_best) begin
                        // strict compare in ascending order keeps the lowest id on ties
                        scan_best  <= scan_val;
                        scan_owner <= ID_W'(scan_idx);
                    end
                    scan_idx <= scan_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_score_tracker_multi.sv
// Directed bench for score_tracker_multi: NUM_PLAYERS=4, ID_W=3 so out-of-range ids can be driven.
module tb_score_tracker_multi;
    localparam int NP = 4;
    localparam int IW = 3;
    localparam int SW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [IW-1:0] req_id;
    logic [SW-1:0] req_score;
    logic          rsp_valid, rsp_err, personal_winner, global_winner;
    logic [SW-1:0] rsp_score, global_best;
    logic [IW-1:0] global_owner;

    int tests = 0;
    int fails = 0;

    // values captured at the response strobe
    int            lat;
    logic          c_err, c_pw, c_gw;
    logic [SW-1:0] c_score;

    always #5 clk = ~clk;

    score_tracker_multi #(.NUM_PLAYERS(NP), .ID_W(IW), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_id(req_id), .req_score(req_score),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .personal_winner(personal_winner),
        .global_winner(global_winner), .rsp_score(rsp_score),
        .global_best(global_best), .global_owner(global_owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its response; called at a negedge.
    task automatic issue(input logic [1:0] op, input logic [IW-1:0] id, input logic [SW-1:0] sc);
        int w;
        req_valid = 1'b1; req_op = op; req_id = id; req_score = sc;
        w = 0;
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        c_err = rsp_err; c_pw = personal_winner; c_gw = global_winner; c_score = rsp_score;
        if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int n_acc, n_rsp;
        logic acc;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_id = '0; req_score = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_gbest", 32'(global_best), 32'd0);
        check("rst_owner", 32'(global_owner), 32'd0);
        issue(2'd1, 3'd1, 14'd0);
        check("q0_lat", lat, 32'd3);
        check("q0_score", 32'(c_score), 32'd0);
        check("q0_err", 32'(c_err), 32'd0);

        issue(2'd0, 3'd1, 14'd100);
        check("s100_lat", lat, 32'd3);
        check("s100_pw", 32'(c_pw), 32'd1);
        check("s100_gw", 32'(c_gw), 32'd1);
        check("s100_score", 32'(c_score), 32'd100);
        check("s100_gbest", 32'(global_best), 32'd100);
        check("s100_owner", 32'(global_owner), 32'd1);
        issue(2'd0, 3'd1, 14'd88);
        check("s88_pw", 32'(c_pw), 32'd0);
        check("s88_gw", 32'(c_gw), 32'd0);
        check("s88_score", 32'(c_score), 32'd100);

        issue(2'd0, 3'd2, 14'd102);
        check("s102_pw", 32'(c_pw), 32'd1);
        check("s102_gw", 32'(c_gw), 32'd1);
        check("s102_owner", 32'(global_owner), 32'd2);
        issue(2'd0, 3'd3, 14'd102);
        check("tie_pw", 32'(c_pw), 32'd1);
        check("tie_gw", 32'(c_gw), 32'd0);
        check("tie_owner", 32'(global_owner), 32'd2);
        check("tie_gbest", 32'(global_best), 32'd102);
        issue(2'd0, 3'd0, 14'd0);
        check("zero_pw", 32'(c_pw), 32'd0);
        check("zero_gw", 32'(c_gw), 32'd0);

        issue(2'd2, 3'd0, 14'd0);
        check("clr_nonowner_lat", lat, 32'd3);
        issue(2'd2, 3'd2, 14'd0);
        check("clr2_lat", lat, 32'd8);
        check("clr2_score", 32'(c_score), 32'd0);
        check("clr2_gbest", 32'(global_best), 32'd102);
        check("clr2_owner", 32'(global_owner), 32'd3);
        issue(2'd2, 3'd3, 14'd0);
        check("clr3_lat", lat, 32'd8);
        check("clr3_gbest", 32'(global_best), 32'd100);
        check("clr3_owner", 32'(global_owner), 32'd1);
        issue(2'd1, 3'd3, 14'd0);
        check("q3_score", 32'(c_score), 32'd0);

        issue(2'd0, 3'd5, 14'd500);
        check("badid_lat", lat, 32'd3);
        check("badid_err", 32'(c_err), 32'd1);
        check("badid_pw", 32'(c_pw), 32'd0);
        check("badid_score", 32'(c_score), 32'd0);
        issue(2'd3, 3'd1, 14'd500);
        check("badop_err", 32'(c_err), 32'd1);
        check("badop_gw", 32'(c_gw), 32'd0);
        check("bad_gbest", 32'(global_best), 32'd100);
        issue(2'd1, 3'd1, 14'd0);
        check("bad_q1_score", 32'(c_score), 32'd100);
        check("bad_q1_err", 32'(c_err), 32'd0);

        // reset while the owner-clear is scanning
        req_valid = 1'b1; req_op = 2'd2; req_id = 3'd1; req_score = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("scan_hold_gbest", 32'(global_best), 32'd100);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_gbest", 32'(global_best), 32'd0);
        check("mid_rst_owner", 32'(global_owner), 32'd0);
        check("mid_rst_score", 32'(rsp_score), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_rsp = 0;
        repeat (8) begin @(negedge clk); if (rsp_valid) n_rsp++; end
        check("mid_rst_no_rsp", n_rsp, 32'd0);

        // back-to-back SUBMITs with req_valid held high
        n_acc = 0; n_rsp = 0;
        req_valid = 1'b1; req_op = 2'd0; req_id = 3'd0; req_score = 14'd10;
        for (int c = 0; c < 16; c++) begin
            acc = req_ready && req_valid;
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid) n_rsp++;
            if (acc) begin
                n_acc++;
                if (n_acc < 4) begin
                    req_id = IW'(n_acc);
                    req_score = SW'(10 * (n_acc + 1));
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        check("b2b_accepts", n_acc, 32'd4);
        check("b2b_rsps", n_rsp, 32'd4);
        check("b2b_gbest", 32'(global_best), 32'd40);
        check("b2b_owner", 32'(global_owner), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
